// File: rtl/gpio_v2.sv
// Parametrised GPIO port: tri-state pads, synchronised pin inputs, atomic
// set/clear of the output register and per-pin edge interrupts with sticky status.
module gpio_v2 #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_w,
  input  logic [2:0]       regsel,
  input  logic [WIDTH-1:0] bus_wdata,
  output logic [WIDTH-1:0] bus_rdata,
  inout  logic [WIDTH-1:0] pins,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_PIN  = 3'd0,
    REG_DIR  = 3'd1,
    REG_PORT = 3'd2,
    REG_SET  = 3'd3,
    REG_CLR  = 3'd4,
    REG_IE   = 3'd5,
    REG_EDGE = 3'd6,
    REG_ISR  = 3'd7
  } reg_e;

  reg_e sel;
  assign sel = reg_e'(regsel);

  logic [WIDTH-1:0] dir_q,   dir_d;
  logic [WIDTH-1:0] port_q,  port_d;
  logic [WIDTH-1:0] ie_q,    ie_d;
  logic [WIDTH-1:0] edge_q,  edge_d;
  logic [WIDTH-1:0] isr_q,   isr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] pin_val;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;

  // Output pins read back their own drive through this same chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pins;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= pin_val;
    end
  end

  assign pin_val = sync_q[SYNC_STAGES-1];
  assign hit     = (edge_q & pin_val & ~prev_q) | (~edge_q & ~pin_val & prev_q);

  always_comb begin
    dir_d   = dir_q;
    port_d  = port_q;
    ie_d    = ie_q;
    edge_d  = edge_q;
    rdata_d = rdata_q;
    clr     = '0;
    if (bus_w) begin
      case (sel)
        REG_DIR:  dir_d  = bus_wdata;
        REG_PORT: port_d = bus_wdata;
        REG_SET:  port_d = port_q | bus_wdata;
        REG_CLR:  port_d = port_q & ~bus_wdata;
        REG_IE:   ie_d   = bus_wdata;
        REG_EDGE: edge_d = bus_wdata;
        REG_ISR:  clr    = bus_wdata;
        default:  ;
      endcase
    end else begin
      case (sel)
        REG_PIN:  rdata_d = pin_val;
        REG_DIR:  rdata_d = dir_q;
        REG_PORT: rdata_d = port_q;
        REG_IE:   rdata_d = ie_q;
        REG_EDGE: rdata_d = edge_q;
        REG_ISR:  rdata_d = isr_q;
        default:  rdata_d = '0;
      endcase
    end
    // A new hit takes priority over a same-cycle write-1-to-clear.
    isr_d = (isr_q & ~clr) | hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q   <= '0;
      port_q  <= '0;
      ie_q    <= '0;
      edge_q  <= '0;
      isr_q   <= '0;
      rdata_q <= '0;
    end else begin
      dir_q   <= dir_d;
      port_q  <= port_d;
      ie_q    <= ie_d;
      edge_q  <= edge_d;
      isr_q   <= isr_d;
      rdata_q <= rdata_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign pins[g] = dir_q[g] ? port_q[g] : 1'bz;
  end

  assign bus_rdata = rdata_q;
  assign irq       = |(isr_q & ie_q);

endmodule

// File: tb/tb_gpio_v2.sv
// Self-checking bench for gpio_v2: directed scenarios plus randomized traffic
// checked against a pad-sample-history reference model.
module tb_gpio_v2;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bus_w = 1'b0;
  logic [2:0]   regsel = '0;
  logic [W-1:0] bus_wdata = '0;
  logic [W-1:0] bus_rdata;
  wire  [W-1:0] pins;
  logic         irq;

  logic [W-1:0] ext_en = '0;
  logic [W-1:0] ext_val = '0;
  logic [W-1:0] ext_mask = '0;

  logic         w1_w = 1'b0;
  logic [2:0]   w1_sel = '0;
  logic [0:0]   w1_wd = '0;
  logic [0:0]   w1_rd;
  wire  [0:0]   pins1;
  logic         irq1;
  logic         w32_w = 1'b0;
  logic [2:0]   w32_sel = '0;
  logic [31:0]  w32_wd = '0;
  logic [31:0]  w32_rd;
  wire  [31:0]  pins32;
  logic         irq32;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] m_dir, m_port, m_ie, m_edge, m_isr, m_rdata;
  logic [W-1:0] hist [S+2];

  always #5 clk = ~clk;

  gpio_v2 #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .bus_w(bus_w), .regsel(regsel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .pins(pins), .irq(irq)
  );

  gpio_v2 #(.WIDTH(1), .SYNC_STAGES(2)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .bus_w(w1_w), .regsel(w1_sel),
    .bus_wdata(w1_wd), .bus_rdata(w1_rd), .pins(pins1), .irq(irq1)
  );

  gpio_v2 #(.WIDTH(32), .SYNC_STAGES(2)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .bus_w(w32_w), .regsel(w32_sel),
    .bus_wdata(w32_wd), .bus_rdata(w32_rd), .pins(pins32), .irq(irq32)
  );

  for (genvar g = 0; g < W; g++) begin : g_ext
    assign pins[g] = ext_en[g] ? ext_val[g] : 1'bz;
    pullup pu (pins[g]);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pad level: our drive if output, else external driver, else pull-up.
  function automatic logic [W-1:0] pad_model();
    return (m_dir & m_port) | (~m_dir & ((ext_en & ext_val) | ~ext_en));
  endfunction

  task automatic model_reset();
    m_dir = '0; m_port = '0; m_ie = '0; m_edge = '0; m_isr = '0; m_rdata = '0;
    for (int i = 0; i < S + 2; i++) hist[i] = '0;
  endtask

  task automatic model_edge(input logic w, input logic [2:0] sel, input logic [W-1:0] wd);
    logic [W-1:0] cur, old, hit, clr;
    for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pad_model();
    cur = hist[S];       // pad as seen S samples ago
    old = hist[S+1];
    hit = 0;
    for (int i = 0; i < W; i++)
      if (cur[i] != old[i] && cur[i] == m_edge[i]) hit[i] = 1'b1;
    if (!w) begin
      case (sel)
        3'd0: m_rdata = cur;
        3'd1: m_rdata = m_dir;
        3'd2: m_rdata = m_port;
        3'd5: m_rdata = m_ie;
        3'd6: m_rdata = m_edge;
        3'd7: m_rdata = m_isr;
        default: m_rdata = '0;
      endcase
    end
    clr = (w && sel == 3'd7) ? wd : '0;
    m_isr = (m_isr & ~clr) | hit;
    if (w) begin
      case (sel)
        3'd1: m_dir = wd;
        3'd2: m_port = wd;
        3'd3: m_port = m_port | wd;
        3'd4: m_port = m_port & ~wd;
        3'd5: m_ie = wd;
        3'd6: m_edge = wd;
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic w, input logic [2:0] sel, input logic [W-1:0] wd);
    logic [W-1:0] newdir;
    newdir = (w && sel == 3'd1) ? wd : '0;
    bus_w = w; regsel = sel; bus_wdata = wd;
    ext_en = ext_mask & ~(m_dir | newdir);
    @(posedge clk);
    model_edge(w, sel, wd);
    @(negedge clk);
    check_eq("rdata", 32'(bus_rdata), 32'(m_rdata));
    check_eq("irq", 32'(irq), 32'(|(m_isr & m_ie)));
    check_eq("pins", 32'(pins), 32'(pad_model()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, '0);
  endtask

  task automatic sw_op(input int which, input logic w, input logic [2:0] sel, input logic [31:0] wd);
    if (which == 1) begin w1_w = w; w1_sel = sel; w1_wd = wd[0:0]; end
    else begin w32_w = w; w32_sel = sel; w32_wd = wd; end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values and released pads
    for (int s = 0; s < 8; s++) begin
      step(1'b0, 3'(s), '0);
      check_eq("rst_rd", 32'(bus_rdata), 32'h0);
    end
    check_eq("rst_pins_z", 32'(pins), 32'hFF);

    // Direction
    step(1'b1, 3'd1, 8'hF0);
    step(1'b1, 3'd2, 8'hA5);
    check_eq("dir_pins", 32'(pins), 32'hAF);

    // Atomic set/clear
    step(1'b1, 3'd2, 8'h0F);
    step(1'b1, 3'd3, 8'h30);
    step(1'b0, 3'd2, '0);
    check_eq("port_set", 32'(bus_rdata), 32'h3F);
    step(1'b1, 3'd4, 8'h05);
    step(1'b0, 3'd2, '0);
    check_eq("port_clr", 32'(bus_rdata), 32'h3A);
    step(1'b0, 3'd3, '0);
    check_eq("rd_set_reg", 32'(bus_rdata), 32'h0);

    // Quiet input pins, configure bit 0 as rising-edge interrupt
    ext_mask = '1; ext_val = '0;
    step(1'b1, 3'd1, 8'h00);
    step(1'b1, 3'd6, 8'h01);
    step(1'b1, 3'd5, 8'h01);
    idle(6);
    step(1'b1, 3'd7, 8'hFF);
    step(1'b0, 3'd7, '0);
    check_eq("isr_clean", 32'(bus_rdata), 32'h0);

    // Synchroniser and edge-to-irq latency
    ext_val[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'd0, '0);
      check_eq("pin_lat", 32'(bus_rdata[0]), 32'(i >= 2));
      check_eq("irq_lat", 32'(irq), 32'(i >= 2));
    end
    step(1'b0, 3'd7, '0);
    check_eq("isr_rise", 32'(bus_rdata), 32'h01);

    // Falling edge on a disabled pin: sticky status, no irq change
    ext_val[1] = 1'b1;
    idle(5);
    ext_val[1] = 1'b0;
    idle(4);
    step(1'b0, 3'd7, '0);
    check_eq("isr_fall", 32'(bus_rdata), 32'h03);
    check_eq("irq_fall", 32'(irq), 32'h1);
    step(1'b1, 3'd7, 8'h01);
    step(1'b0, 3'd7, '0);
    check_eq("isr_w1c", 32'(bus_rdata), 32'h02);
    check_eq("irq_w1c", 32'(irq), 32'h0);

    // Set wins over a same-cycle clear
    ext_val[0] = 1'b0; idle(4);
    ext_val[0] = 1'b1; idle(4);
    ext_val[0] = 1'b0; idle(4);
    ext_val[0] = 1'b1;
    step(1'b0, 3'd0, '0);
    step(1'b0, 3'd0, '0);
    step(1'b1, 3'd7, 8'h01);
    check_eq("collide_irq", 32'(irq), 32'h1);
    step(1'b0, 3'd7, '0);
    check_eq("collide_isr", 32'(bus_rdata), 32'h03);

    // Asynchronous reset mid-operation
    step(1'b1, 3'd1, 8'hFF);
    step(1'b0, 3'd7, '0);
    check_eq("pre_rst_isr", 32'(bus_rdata), 32'h03);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_pins", 32'(pins), 32'hFF);
    check_eq("arst_irq", 32'(irq), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 3'd7, '0);
    check_eq("post_rst_isr", 32'(bus_rdata), 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic w;
      if ($urandom_range(0, 7) == 0) ext_mask = W'($urandom);
      if ($urandom_range(0, 2) == 0) ext_val[$urandom_range(0, W-1)] ^= 1'b1;
      w = ($urandom_range(0, 2) == 0);
      step(w, 3'($urandom_range(0, 7)), W'($urandom));
    end
    bus_w = 1'b0;

    // Width sweep: set/clear on WIDTH=1 and WIDTH=32
    sw_op(1, 1'b1, 3'd2, 32'h0);
    sw_op(1, 1'b1, 3'd3, 32'h1);
    sw_op(1, 1'b0, 3'd2, 32'h0);
    check_eq("w1_set", 32'(w1_rd), 32'h1);
    sw_op(1, 1'b0, 3'd3, 32'h0);
    check_eq("w1_rd_set", 32'(w1_rd), 32'h0);
    sw_op(1, 1'b1, 3'd4, 32'h1);
    sw_op(1, 1'b0, 3'd2, 32'h0);
    check_eq("w1_clr", 32'(w1_rd), 32'h0);

    sw_op(32, 1'b1, 3'd2, 32'h0000FFFF);
    sw_op(32, 1'b1, 3'd3, 32'hF0F00000);
    sw_op(32, 1'b0, 3'd2, 32'h0);
    check_eq("w32_set", w32_rd, 32'hF0F0FFFF);
    sw_op(32, 1'b0, 3'd3, 32'h0);
    check_eq("w32_rd_set", w32_rd, 32'h0);
    sw_op(32, 1'b1, 3'd4, 32'h000F000F);
    sw_op(32, 1'b0, 3'd2, 32'h0);
    check_eq("w32_clr", w32_rd, 32'hF0F0FFF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
